// File: rtl/klp32_pkg.sv
// klp32_pkg: shared types and constants for the KLP32V1 program loader.
// Contents: loader FSM state enum, frame sync byte, count width and the
// instruction-memory word-address helper.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CHK state.
package klp32_pkg;

   localparam logic [7:0]  LOADER_SYNC_BYTE = 8'hA5;
   localparam int unsigned LOADER_CNT_W     = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN0 = 3'd1,
      ST_LEN1 = 3'd2,
      ST_DATA = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK  = 3'd4,
`endif
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } loader_state_t;

   // Byte address of word 'idx' relative to 'base', wrapping modulo 2^32.
   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input logic [LOADER_CNT_W-1:0] idx);
      return base + {14'h0000, idx, 2'b00};
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: valid/ready byte stream feeding the program loader.
// Signals: in_valid (byte present), in_data (stream byte), in_ready (sink
// accepts). master = byte source, slave = loader.
interface imem_loader_if;

   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the KLP32V1 instruction memory.
// Frame: 0xA5, N[7:0], N[15:8], N x 4 little-endian data bytes, and an XOR
// checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_if (slave)     byte stream in_valid/in_data/in_ready
//   o_imem_we/addr/wdata  single-cycle instruction-memory write port
//   o_cpu_hold        core reset; high until a valid image is loaded
//   o_done, o_error   last frame completed / sticky frame error
//   o_words_loaded    words written in the current or last frame
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import klp32_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    reset,
   imem_loader_if.slave            in_if,
   output logic                    o_imem_we,
   output logic [31:0]             o_imem_addr,
   output logic [31:0]             o_imem_wdata,
   output logic                    o_cpu_hold,
   output logic                    o_done,
   output logic                    o_error,
   output logic [LOADER_CNT_W-1:0] o_words_loaded
);

   loader_state_t            state_q;
   logic [LOADER_CNT_W-1:0]  cnt_q;
   logic [LOADER_CNT_W-1:0]  idx_q;
   logic [1:0]               bcnt_q;
   logic [23:0]              word_q;
   logic                     ready_q;
   logic                     we_q;
   logic [31:0]              addr_q;
   logic [31:0]              wdata_q;
   logic                     hold_q;
   logic                     done_q;
   logic                     error_q;
   logic [LOADER_CNT_W-1:0]  wl_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]               csum_q;
`endif

   logic                    xfer;
   logic [LOADER_CNT_W-1:0] len_d;
   logic [31:0]             word_d;
   logic                    last_word;

   assign xfer      = in_if.in_valid & ready_q;
   assign len_d     = {in_if.in_data, cnt_q[7:0]};
   // Newest byte enters at the top, so after four bytes byte 0 sits in [7:0].
   assign word_d    = {in_if.in_data, word_q};
   assign last_word = (idx_q == (cnt_q - LOADER_CNT_W'(1)));

   // Loader FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         wl_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         ready_q <= 1'b1;
         we_q    <= 1'b0;
         if (xfer) begin
            case (state_q)
               ST_IDLE, ST_DONE: begin
                  if (in_if.in_data == LOADER_SYNC_BYTE) begin
                     state_q <= ST_LEN0;
                     done_q  <= 1'b0;
                     hold_q  <= 1'b1;
                     wl_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum_q  <= '0;
`endif
                  end
               end
               ST_LEN0: begin
                  cnt_q   <= {8'h00, in_if.in_data};
                  state_q <= ST_LEN1;
               end
               ST_LEN1: begin
                  cnt_q  <= len_d;
                  idx_q  <= '0;
                  bcnt_q <= '0;
                  if ({16'h0000, len_d} > DEPTH) begin
                     state_q <= ST_ERR;
                     error_q <= 1'b1;
                  end else if (len_d == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_q <= ST_CHK;
`else
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     hold_q  <= 1'b0;
`endif
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  word_q <= word_d[31:8];
                  bcnt_q <= bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ in_if.in_data;
`endif
                  if (bcnt_q == 2'd3) begin
                     we_q    <= 1'b1;
                     addr_q  <= word_addr(BASE_ADDR, idx_q);
                     wdata_q <= word_d;
                     idx_q   <= idx_q + LOADER_CNT_W'(1);
                     wl_q    <= idx_q + LOADER_CNT_W'(1);
                     if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q <= ST_CHK;
`else
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
`endif
                     end
                  end
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               ST_CHK: begin
                  if (in_if.in_data == csum_q) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     hold_q  <= 1'b0;
                  end else begin
                     state_q <= ST_ERR;
                     error_q <= 1'b1;
                  end
               end
`endif
               ST_ERR: begin
                  // Sticky: bytes are swallowed until reset.
                  state_q <= ST_ERR;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign in_if.in_ready  = ready_q;
   assign o_imem_we       = we_q;
   assign o_imem_addr     = addr_q;
   assign o_imem_wdata    = wdata_q;
   assign o_cpu_hold      = hold_q;
   assign o_done          = done_q;
   assign o_error         = error_q;
   assign o_words_loaded  = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader. A frame-level
// model derives every expected output from the byte position inside the frame.
module tb_imem_loader;

   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        o_imem_we;
   logic [31:0] o_imem_addr;
   logic [31:0] o_imem_wdata;
   logic        o_cpu_hold;
   logic        o_done;
   logic        o_error;
   logic [15:0] o_words_loaded;

   imem_loader_if bus();

   imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_if          (bus.slave),
      .o_imem_we      (o_imem_we),
      .o_imem_addr    (o_imem_addr),
      .o_imem_wdata   (o_imem_wdata),
      .o_cpu_hold     (o_cpu_hold),
      .o_done         (o_done),
      .o_error        (o_error),
      .o_words_loaded (o_words_loaded)
   );

   always #5 clk = ~clk;

   int npass = 0;
   int ntot  = 0;

   // Model state: expected outputs after the next clock edge.
   bit          chk_en = 1'b0;
   bit          exp_ready, exp_we, exp_hold, exp_done, exp_err;
   logic [31:0] exp_addr, exp_wdata;
   logic [15:0] exp_wl;
   bit          in_frame = 1'b0;
   logic [7:0]  frame[$];
   logic [7:0]  fr[$];
   logic [63:0] dut_wr[$];

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   // Frame-position model: byte p of the frame (after sync) decides the outputs.
   function automatic void model_step(input bit rst, input bit v, input logic [7:0] b);
      bit         acc;
      int         p, n, len, j;
      logic [7:0] x;
      acc    = v && exp_ready;
      exp_we = 1'b0;
      if (rst) begin
         exp_ready = 1'b0; exp_hold = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
         exp_wl = '0; exp_addr = BASE; exp_wdata = '0;
         in_frame = 1'b0; frame.delete(); chk_en = 1'b1;
         return;
      end
      exp_ready = 1'b1;
      if (!acc || exp_err) return;
      if (!in_frame) begin
         if (b == 8'hA5) begin
            in_frame = 1'b1; frame.delete();
            exp_done = 1'b0; exp_hold = 1'b1; exp_wl = '0;
         end
         return;
      end
      frame.push_back(b);
      p = frame.size();
      if (p < 2) return;
      n = int'({frame[1], frame[0]});
      if (n > int'(DEPTH)) begin
         exp_err = 1'b1; in_frame = 1'b0;
         return;
      end
      len = 2 + 4 * n + (CSUM ? 1 : 0);
      if (p > 2 && p <= 2 + 4 * n && (p - 2) % 4 == 0) begin
         j         = (p - 2) / 4 - 1;
         exp_we    = 1'b1;
         exp_addr  = BASE + 32'(4 * j);
         exp_wdata = {frame[p-1], frame[p-2], frame[p-3], frame[p-4]};
         exp_wl    = 16'(j + 1);
      end
      if (p == len) begin
         in_frame = 1'b0;
         x = 8'h00;
         for (int i = 2; i < 2 + 4 * n; i++) x ^= frame[i];
         if (!CSUM || x == frame[len-1]) begin
            exp_done = 1'b1; exp_hold = 1'b0;
         end else begin
            exp_err = 1'b1;
         end
      end
   endfunction

   // Compare process: one sample per cycle, 1 time unit after the edge.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("in_ready",     32'(bus.in_ready),   32'(exp_ready));
         check("imem_we",      32'(o_imem_we),      32'(exp_we));
         check("cpu_hold",     32'(o_cpu_hold),     32'(exp_hold));
         check("done",         32'(o_done),         32'(exp_done));
         check("error",        32'(o_error),        32'(exp_err));
         check("words_loaded", 32'(o_words_loaded), 32'(exp_wl));
         if (exp_we) begin
            check("imem_addr",  o_imem_addr,  exp_addr);
            check("imem_wdata", o_imem_wdata, exp_wdata);
         end
         if (o_imem_we === 1'b1) dut_wr.push_back({o_imem_addr, o_imem_wdata});
      end
   end

   task automatic cycle(input bit rst, input bit v, input logic [7:0] b);
      @(negedge clk);
      reset        = rst;
      bus.in_valid = v;
      bus.in_data  = b;
      model_step(rst, v, b);
   endtask

   task automatic send(input logic [7:0] b, input int maxgap);
      repeat ($urandom_range(0, maxgap)) cycle(1'b0, 1'b0, 8'($urandom));
      cycle(1'b0, 1'b1, b);
   endtask

   task automatic send_fr(input int maxgap);
      foreach (fr[i]) send(fr[i], maxgap);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
   endtask

   function automatic void image1(input bit trailer, input logic [7:0] t);
      fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
             8'h93, 8'h07, 8'h40, 8'h00};
      if (trailer) fr.push_back(t);
   endfunction

   // Random frame: n words, trailer corrupted when 'bad'.
   function automatic void build_frame(input int n, input bit bad);
      logic [7:0] x, d;
      x = 8'h00;
      fr.delete();
      fr.push_back(8'hA5);
      fr.push_back(8'(n));
      fr.push_back(8'(n >> 8));
      for (int i = 0; i < 4 * n; i++) begin
         d = 8'($urandom);
         x ^= d;
         fr.push_back(d);
      end
      if (CSUM) fr.push_back(bad ? ~x : x);
   endfunction

   task automatic check_img1();
      check("img1_nwr", 32'(dut_wr.size()), 32'd2);
      if (dut_wr.size() == 2) begin
         check("img1_addr0", dut_wr[0][63:32], 32'h0000_0000);
         check("img1_data0", dut_wr[0][31:0],  32'h0050_0513);
         check("img1_addr1", dut_wr[1][63:32], 32'h0000_0004);
         check("img1_data1", dut_wr[1][31:0],  32'h0040_0793);
      end
   endtask

   initial begin
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // Reset values.
      do_reset();
      check("rst_ready", 32'(bus.in_ready), 32'd0);
      check("rst_hold",  32'(o_cpu_hold),   32'd1);
      check("rst_done",  32'(o_done),       32'd0);
      check("rst_err",   32'(o_error),      32'd0);
      check("rst_wl",    32'(o_words_loaded), 32'd0);
      check("rst_we",    32'(o_imem_we),    32'd0);
      check("rst_addr",  o_imem_addr,       BASE);
      check("rst_wdata", o_imem_wdata,      32'd0);

      // Basic image, back to back; hold falls together with the last write.
      dut_wr.delete();
      image1(CSUM, 8'h92);
      send_fr(0);
      cycle(1'b0, 1'b0, 8'h00);
      check("img1_hold_fall", 32'(o_cpu_hold), 32'd0);
      check("img1_done",      32'(o_done),     32'd1);
      if (!CSUM) check("img1_last_we", 32'(o_imem_we), 32'd1);
      check("img1_wl", 32'(o_words_loaded), 32'd2);
      repeat (2) cycle(1'b0, 1'b0, 8'h00);
      check_img1();

      // Garbage then zero-length frame.
      dut_wr.delete();
      fr = '{8'hFF, 8'h00, 8'hA5, 8'h00, 8'h00};
      if (CSUM) fr.push_back(8'h00);
      send_fr(1);
      repeat (2) cycle(1'b0, 1'b0, 8'h00);
      check("zero_nwr",  32'(dut_wr.size()), 32'd0);
      check("zero_done", 32'(o_done),        32'd1);
      check("zero_hold", 32'(o_cpu_hold),    32'd0);

      // Oversize frame, then a valid image that must be ignored.
      dut_wr.delete();
      fr = '{8'hA5, 8'h01, 8'h01};
      send_fr(0);
      image1(CSUM, 8'h92);
      send_fr(1);
      repeat (2) cycle(1'b0, 1'b0, 8'h00);
      check("ovr_err",  32'(o_error),       32'd1);
      check("ovr_hold", 32'(o_cpu_hold),    32'd1);
      check("ovr_nwr",  32'(dut_wr.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Bad checksum trailer.
      do_reset();
      image1(1'b1, 8'h93);
      send_fr(0);
      repeat (2) cycle(1'b0, 1'b0, 8'h00);
      check("csum_bad_err",  32'(o_error),    32'd1);
      check("csum_bad_hold", 32'(o_cpu_hold), 32'd1);
`endif

      // Reset after 6 data bytes, then full reload.
      do_reset();
      image1(1'b0, 8'h00);
      for (int i = 0; i < 9; i++) send(fr[i], 0);
      do_reset();
      check("mid_hold", 32'(o_cpu_hold),     32'd1);
      check("mid_wl",   32'(o_words_loaded), 32'd0);
      check("mid_done", 32'(o_done),         32'd0);
      dut_wr.delete();
      image1(CSUM, 8'h92);
      send_fr(0);
      repeat (2) cycle(1'b0, 1'b0, 8'h00);
      check_img1();

      // Same image with random 0-3 cycle gaps.
      dut_wr.delete();
      image1(CSUM, 8'h92);
      send_fr(3);
      repeat (2) cycle(1'b0, 1'b0, 8'h00);
      check_img1();
      check("gap_done", 32'(o_done), 32'd1);

      // Largest legal frame.
      dut_wr.delete();
      build_frame(int'(DEPTH), 1'b0);
      send_fr(0);
      repeat (2) cycle(1'b0, 1'b0, 8'h00);
      check("max_nwr",  32'(dut_wr.size()),  32'(DEPTH));
      check("max_done", 32'(o_done),         32'd1);
      check("max_wl",   32'(o_words_loaded), 32'(DEPTH));

      // Randomized frames with garbage, errors and occasional mid-frame resets.
      for (int f = 0; f < 40; f++) begin
         int n;
         repeat ($urandom_range(0, 2)) send(8'($urandom_range(0, 8'hA4)), 2);
         n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH + 1, 16'hFFFF))
                                         : int'($urandom_range(0, 6));
         build_frame(n, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) begin
            int cut;
            cut = $urandom_range(1, fr.size());
            for (int i = 0; i < cut; i++) send(fr[i], 3);
            do_reset();
         end else begin
            send_fr(3);
         end
         repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 8'($urandom));
         if (exp_err) do_reset();
      end
      repeat (3) cycle(1'b0, 1'b0, 8'h00);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader: the writer for the KLP32V1 instruction memory that the core fetches from. It receives a framed program image over a valid/ready byte interface and assembles little-endian 32-bit words. It writes those words into instruction memory through a single-cycle write port and holds the core in reset until a complete, valid image has been loaded.

## Interface
- Parameters:
- `DEPTH`, 256: instruction memory size in words; the maximum legal word count.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs when `in_valid && in_ready` is high on a clock edge.
- `o_imem_we`  out  1  one-cycle instruction-memory write strobe.
- `o_imem_addr`  out  32  byte address of the write.
- `o_imem_wdata`  out  32  instruction word.
- `o_cpu_hold`  out  1  drives the core's `reset`; high while no valid image is present.
- `o_done`  out  1  last load completed successfully.
- `o_error`  out  1  frame error; sticky until `reset`.
- `o_words_loaded`  out  16  words written in the current or last frame.

## Operation
- Frame format: sync byte 0xA5, then word count N (16 bits, low byte first), then N×4 data bytes (each word low byte first), then, if configured, a checksum byte.
- FSM states:
- IDLE: waits for a sync byte; every non-0xA5 byte is discarded.
- LEN0: latches the count low byte.
- LEN1: latches the count high byte.
  - If N > `DEPTH`, go to ERR.
  - If N == 0, go to DONE (or CHK).
  - Otherwise go to DATA.
- DATA: a 2-bit byte counter shifts bytes into the word register.
  - On the 4th byte, issue a write and increment the word index.
  - After word N, go to DONE (or CHK).
- CHK: compares the received byte with the running checksum; match goes to DONE, mismatch goes to ERR.
- DONE: `o_done`=1 and `o_cpu_hold`=0. A new 0xA5 byte starts a new frame: go to LEN0, `o_done`=0, `o_cpu_hold`=1, `o_words_loaded` cleared.
- ERR: `o_error`=1 and `o_cpu_hold`=1. All bytes are accepted and discarded; only `reset` exits this state.
- `in_ready` is 1 in every state after reset; the loader never back-pressures.
- Address arithmetic: `o_imem_addr` = `BASE_ADDR` + 4×index, computed modulo 2^32. Index never exceeds `DEPTH`−1 because N is checked in LEN1.
- Word assembly: byte k of a word (k = 0..3) lands in bits [8k+7:8k].

## Timing
- Reset values:
- state IDLE.
- `in_ready`=0 during the reset cycle, 1 afterwards.
- `o_imem_we`=0, `o_imem_addr`=`BASE_ADDR`, `o_imem_wdata`=0.
- `o_cpu_hold`=1, `o_done`=0, `o_error`=0, `o_words_loaded`=0.
- Write latency: `o_imem_we` is high for exactly the one cycle after the edge that accepts a word's 4th byte. Address and data are valid in that same cycle. `o_words_loaded` increments on the same edge as the write.
- Back-to-back bytes every cycle are supported; idle cycles between bytes are allowed anywhere in the frame.
- `o_cpu_hold` falls, and `o_done` rises, on the edge that enters DONE: one cycle after the last data or checksum byte is accepted. The final write strobe and the fall of hold occur in the same cycle.
- A `reset` asserted mid-frame aborts the frame. Memory contents are then partially written; `o_cpu_hold` returns to 1.
- If the frame ends in error, already-written words remain in memory and the core stays held.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN`: when defined, the frame carries a trailing checksum byte.
  - The checksum is the XOR of all N×4 data bytes; it is 0x00 when N=0.
  - The FSM passes through CHK before DONE.
- When not defined, CHK does not exist and the last data byte leads directly to DONE.

## Structure
- Shared package `klp32_pkg`:
  - State enum `loader_state_t`.
  - `LOADER_SYNC_BYTE` = 8'hA5.
  - Width constant `LOADER_CNT_W` = 16.
- Single module. The word assembler (shift register plus byte counter) is inline and has no sub-module.

## Test plan
- Load image: A5 02 00 13 05 50 00 93 07 40 00.
  - Expect writes 0x00500513 @0x0 and 0x00400793 @0x4.
  - Expect `o_words_loaded`=2, `o_done`=1, hold falls one cycle after the last byte.
- Garbage then zero-length frame: FF 00 A5 00 00 → no writes, `o_done`=1, hold=0.
- Oversize frame: A5 01 01 (N=257 > 256) → `o_error`=1, hold=1, no writes. Later bytes are accepted and ignored.
- With checksum: the image from the first test plus trailer 0x92 → `o_done`=1. The same image with trailer 0x93 → `o_error`=1, hold stays 1.
- `reset` pulsed after 6 data bytes → all outputs return to reset values. A full reload then succeeds.
- Bytes sent with random 0–3 cycle gaps → same writes and timing relative to the last accepted byte as in the first test.
